// File: rtl/l2_line_responder_pkg.sv
// Shared types and constants for the L2 line responder.
package l2_line_responder_pkg;

  localparam int LC3B_LINE_BITS        = 128;
  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } l2_resp_state_t;

  function automatic logic [15:0] line_align(input logic [15:0] addr, input int offset_bits);
    logic [15:0] mask;
    mask = 16'hFFFF << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/l2_line_responder_if.sv
// Arbiter-to-L2 line request interface.
// Handshake: the arbiter raises read or write and holds address/wdata stable until it samples resp=1;
// resp is a single-cycle pulse, and rdata is valid in that cycle and held afterwards.
interface l2_line_responder_if;
  logic [15:0]                                       L2_mem_address;
  logic                                              L2_mem_read;
  logic                                              L2_mem_write;
  logic [l2_line_responder_pkg::LC3B_LINE_BITS-1:0] L2_mem_wdata;
  logic                                              L2_mem_resp;
  logic [l2_line_responder_pkg::LC3B_LINE_BITS-1:0] L2_mem_rdata;

  modport master (
    output L2_mem_address, L2_mem_read, L2_mem_write, L2_mem_wdata,
    input  L2_mem_resp, L2_mem_rdata
  );

  modport slave (
    input  L2_mem_address, L2_mem_read, L2_mem_write, L2_mem_wdata,
    output L2_mem_resp, L2_mem_rdata
  );
endinterface

// File: rtl/l2_line_responder_line_beat_shifter.sv
// Line register with a beat counter: parallel load, beat output mux, beat capture, last-beat flag.
module l2_line_responder_line_beat_shifter #(
  parameter int BEAT_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              beat_en,
  input  logic              capture,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line_next,
  output logic              done
);
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [LINE_W-1:0] line_q, line_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load) begin
      line_d = load_data;
      cnt_d  = '0;
    end else if (beat_en) begin
      if (capture) line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = beat_in;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  // line_next includes the beat landing on this edge, so the final line is usable at done.
  assign line_next = line_d;
  assign beat_out  = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
  assign done      = beat_en && (cnt_q == CW'(NBEATS - 1));
endmodule

// File: rtl/l2_line_responder.sv
// Services one L2 line read/write over a beat-serial physical memory bus.
// Optional one-entry read line buffer enabled by defining L2_RESP_LINE_BUF_EN.
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int BEAT_W           = 32,
  parameter int LINE_OFFSET_BITS = LC3B_LINE_OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  l2_line_responder_if.slave       l2,
  output logic [15:0]              pmem_address,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [BEAT_W-1:0]        pmem_wdata,
  input  logic [BEAT_W-1:0]        pmem_rdata,
  input  logic                     pmem_ready,
  output l2_resp_state_t           state_dbg
);
  localparam int LW = LC3B_LINE_BITS;

  l2_resp_state_t state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic           is_write_q, is_write_d;
  logic [LW-1:0]  rdata_q, rdata_d;
  logic           pmem_read_q, pmem_read_d;
  logic           pmem_write_q, pmem_write_d;
  logic           resp_q, resp_d;

  logic           sh_load, sh_beat_en, sh_done;
  logic [LW-1:0]  sh_load_data, sh_line_next;

  logic           req_rd, req_wr, buf_hit;
  logic [15:0]    req_addr;
  logic [LW-1:0]  buf_data;

  // A simultaneous read and write is serviced as the write.
  assign req_wr   = l2.L2_mem_write;
  assign req_rd   = l2.L2_mem_read & ~l2.L2_mem_write;
  assign req_addr = line_align(l2.L2_mem_address, LINE_OFFSET_BITS);

  l2_line_responder_line_beat_shifter #(.BEAT_W(BEAT_W), .LINE_W(LW)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (sh_load_data),
    .beat_en   (sh_beat_en),
    .capture   (~is_write_q),
    .beat_in   (pmem_rdata),
    .beat_out  (pmem_wdata),
    .line_next (sh_line_next),
    .done      (sh_done)
  );

`ifdef L2_RESP_LINE_BUF_EN
  logic          buf_valid_q, buf_valid_d;
  logic [15:0]   buf_tag_q, buf_tag_d;
  logic [LW-1:0] buf_data_q, buf_data_d;

  assign buf_hit  = (state_q == IDLE) && req_rd && buf_valid_q && (buf_tag_q == req_addr);
  assign buf_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == IDLE && req_wr && buf_valid_q && buf_tag_q == req_addr)
      buf_data_d = l2.L2_mem_wdata;
    if (state_q == BURST && sh_done && !is_write_q) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = addr_q;
      buf_data_d  = sh_line_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    is_write_d   = is_write_q;
    rdata_d      = rdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    resp_d       = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_beat_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (buf_hit) begin
          rdata_d = buf_data;
          resp_d  = 1'b1;
          state_d = RESP;
        end else if (req_rd || req_wr) begin
          addr_d       = req_addr;
          is_write_d   = req_wr;
          sh_load      = 1'b1;
          sh_load_data = req_wr ? l2.L2_mem_wdata : '0;
          pmem_read_d  = req_rd;
          pmem_write_d = req_wr;
          state_d      = BURST;
        end
      end
      BURST: begin
        sh_beat_en = pmem_ready;
        if (sh_done) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          resp_d       = 1'b1;
          state_d      = RESP;
          if (!is_write_q) rdata_d = sh_line_next;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      rdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      resp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      is_write_q   <= is_write_d;
      rdata_q      <= rdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      resp_q       <= resp_d;
    end
  end

  assign l2.L2_mem_resp  = resp_q;
  assign l2.L2_mem_rdata = rdata_q;
  assign pmem_address    = addr_q;
  assign pmem_read       = pmem_read_q;
  assign pmem_write      = pmem_write_q;
  assign state_dbg       = state_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state_q == IDLE)
      assert (!(l2.L2_mem_read && l2.L2_mem_write))
        else $warning("l2_line_responder: read and write requested together, servicing the write");
  end
`endif
endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Responder end of the arbiter-to-L2 line interface: accepts one cache-line read or write from the arbiter (L2_mem_* signals) and services it from physical memory over a narrower beat-serial bus.
- Sits below the arbiter, in place of/behind the L2 array.
- Serialises 128-bit write lines into beats, deserialises read beats into a line, then pulses L2_mem_resp for exactly one cycle.

Parameters:
- BEAT_W, 32, physical-memory beat width in bits; must divide 128; NBEATS = 128/BEAT_W.
- LINE_OFFSET_BITS, 4, byte-offset bits forced to zero on pmem_address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- L2_mem_address  in  16  line address from arbiter (lc3b_word).
- L2_mem_read  in  1  read request, held by arbiter until resp.
- L2_mem_write  in  1  write request, held by arbiter until resp.
- L2_mem_wdata  in  128  write line (lc3b_c_line).
- L2_mem_resp  out  1  one-cycle completion pulse.
- L2_mem_rdata  out  128  read line, valid during resp and held after.
- pmem_address  out  16  line-aligned physical address.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_wdata  out  BEAT_W  current write beat.
- pmem_rdata  in  BEAT_W  read beat, valid when pmem_ready=1.
- pmem_ready  in  1  beat transferred on this rising edge.

Behaviour:
- Reset (async, rst_n=0): state IDLE; L2_mem_resp=0, L2_mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, beat counter=0. Reset mid-burst aborts immediately; no resp is issued for the aborted request.
- FSM: IDLE -> BURST -> RESP -> IDLE.
- IDLE: on an edge with L2_mem_read or L2_mem_write=1:
  - Latch the address with the low LINE_OFFSET_BITS cleared.
  - Latch the op and, for a write, L2_mem_wdata.
  - Clear the counter and go to BURST.
  - If read and write are both 1, the write is taken (read ignored); flagged by a simulation-only assertion.
- BURST:
  - pmem_read or pmem_write is held high (registered) with a stable pmem_address.
  - pmem_wdata = beat[counter] of the latched line; beat 0 = bits [BEAT_W-1:0], ascending.
  - Each edge with pmem_ready=1 transfers one beat (reads shift pmem_rdata into slot counter) and increments the counter.
  - On the edge transferring beat NBEATS-1, go to RESP.
  - pmem_ready=0 stalls indefinitely with no timeout.
- RESP:
  - L2_mem_resp=1 for exactly this cycle; pmem_read and pmem_write are 0.
  - For reads, L2_mem_rdata is the fully assembled line, updated only on a read completion.
  - Return to IDLE unconditionally. A request seen in the following IDLE cycle is a new request (the arbiter drops its request on the resp edge).
- Latency with pmem_ready tied to 1: request first sampled at cycle 0, resp at cycle NBEATS+1 (cycle 5 for BEAT_W=32).
- Inputs L2_mem_* are ignored outside IDLE; changes mid-burst have no effect.
- Counter width is clog2(NBEATS), minimum 1 bit; no wrap occurs because the transition leaves BURST on the last beat.

Optional Feature:
- Macro: L2_RESP_LINE_BUF_EN.
- Defined: keep a one-entry buffer (valid, tag=line address, data).
  - A read in IDLE whose address matches a valid entry goes directly to RESP (resp the next cycle) with the buffered data; no pmem traffic.
  - Every completed read fills the buffer.
  - A write to the buffered address updates the buffered data with L2_mem_wdata; the write burst still happens.
  - Reset clears valid.
- Undefined: every read performs a full burst.

Decomposition:
- lc3b_types gains:
  - LC3B_LINE_BITS = 128 and LC3B_LINE_OFFSET_BITS = 4.
  - Enum typedef l2_resp_state_t {IDLE, BURST, RESP}.
- One sub-module is natural: line_beat_shifter. It holds a 128-bit register, beat counter, parallel load, beat output mux, beat input write, and done flag, parameterised by BEAT_W.

Test Plan:
- Read, pmem_ready=1 always, address 16'h1237, memory returns beats 32'h00000001..32'h00000004 -> pmem_address=16'h1230; resp at cycle 5; L2_mem_rdata = 128'h00000004_00000003_00000002_00000001.
- Write, line 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF -> pmem_wdata beats 89ABCDEF, 01234567, CAFEBABE, DEADBEEF in order; one resp; pmem_write=0 in the resp cycle.
- Read with pmem_ready toggling 1,0,0,1,... -> exactly 4 beats captured; resp one cycle after the 4th ready; no resp while stalled.
- rst_n pulsed low after beat 2 of a read -> outputs zero asynchronously; no resp; next read completes normally with fresh data.
- Read and write asserted together -> write burst performed, assertion fires, single resp.
- With L2_RESP_LINE_BUF_EN: repeat read of 16'h1230 -> resp at cycle 1 with no pmem_read. Then write to 16'h1230 followed by a read -> the read returns the written data without a burst.
